gpu_line_irq_ctrl: RTL
======================

// Module: gpu_line_irq_ctrl
// PURPOSE
//  CPU-mapped interrupt controller for the GPU scan position. Samples the pixel/line counters
//  from the video timing path and detects vblank start and a programmable compare line.
//  Latches both as pending flags, counts frames, and raises one level irq to the MIPS core.
//  Sits on the CPU data bus next to the GPU status register; software uses it for tear-free
//  framebuffer updates.
// PARAMETERS
//  ADDRESS        'h70000010  byte base address; 16-byte aligned; occupies 4 words
//  VISIBLE_LINES  480         line number at which vblank starts
//  LINE_CMP_INIT  16'd0       reset value of LINE_CMP
// PORTS
//  cpu_clk       in     1   CPU clock; all state on posedge
//  reset         in     1   asynchronous, active-high reset
//  data_address  in    30   CPU word address (byte address >> 2)
//  data_bus      inout 32   CPU data bus; driven only during a read hit, else 'z
//  data_cs       in     1   bus chip select
//  data_rw       in     1   1 = write, 0 = read
//  pixel         in    16   current pixel (x) position from timing generator
//  line          in    16   current line (y) position from timing generator
//  irq           out    1   level interrupt to CPU
// BEHAVIOUR
//  Decode: hit = data_cs && data_address[29:2] == ADDRESS>>4; word offset = data_address[1:0].
//  Register map (word offset):
//   0 CTRL      RW  [0] vblank_en, [1] line_en; other bits read 0
//   1 LINE_CMP  RW  [15:0] compare line; [31:16] read 0
//   2 STATUS    R/W1C  [0] vblank_pend, [1] line_pend; [31:16] frame_cnt (read-only)
//   3 POS       RO  {pixel_q, line_q}, captured this cycle; writes ignored
//  Read: combinational; data_bus = reg value when hit && !data_rw, else 32'bz.
//  Write: when hit && data_rw, takes effect at the next posedge.
//  Sampling: pixel_q/line_q register pixel/line every cycle. prev_valid is 0 after reset and
//   goes 1 after the first sample. line_prev holds the previous line_q.
//  Events are valid only while prev_valid = 1:
//   vb_evt = (line_q == VISIBLE_LINES) && (line_prev != VISIBLE_LINES)
//   ln_evt = (line_q == LINE_CMP) && (line_prev != LINE_CMP)
//   Edge-triggered: a line that stays constant fires once.
//  Pending: vb_evt sets vblank_pend and ln_evt sets line_pend. Each is set regardless of its
//   enable, so software can poll. A W1C write clears the bits written as 1.
//  Same-cycle set and W1C clear on a bit -> set wins (bit stays 1).
//  frame_cnt: 16-bit; +1 on each vb_evt; wraps 16'hFFFF -> 0. No write access.
//  irq = (vblank_pend & vblank_en) | (line_pend & line_en). Registered terms only, so irq
//   rises one cycle after the event edge cycle.
//  LINE_CMP write: applies to events from the next cycle on. If line_q already equals the new
//   value, no event fires until the line leaves and re-enters that value.
//  Reset (async, any time): CTRL = 0, LINE_CMP = LINE_CMP_INIT, pend = 0, frame_cnt = 0,
//   pixel_q = line_q = line_prev = 0, prev_valid = 0. Outputs: irq = 0, data_bus = 'z.
//  Reset mid-frame: no spurious event on the first cycle after release.
//  Writes to offset 3 and to undefined bits are ignored.
// TESTING
//  1 Reset with line=480 held -> no vb_evt ever; STATUS=0; irq=0; data_bus='z with cs=0.
//  2 CTRL=1, step line 479->480 -> vblank_pend=1 one cycle later, irq=1, frame_cnt=1.
//    Write STATUS=1 -> irq=0.
//  3 LINE_CMP=100, CTRL=2, line 99->100->100->101 -> exactly one line_pend set.
//    With CTRL=0: pend=1, irq=0.
//  4 W1C of bit0 in the same cycle as a vb_evt -> vblank_pend stays 1.
//  5 Preload 65535 vblanks -> frame_cnt=16'hFFFF; next vblank -> 0.
//  6 Read offset 3 with pixel=0x12, line=0x34 -> 0x00120034.
//    Read at ADDRESS+0x20 -> bus 'z. Assert reset mid-frame -> all regs at reset values.

Source files
------------

// File: rtl/gpu_line_irq_ctrl.sv
// -----------------------------------------------------------------------------
// gpu_line_irq_ctrl
//
// CPU-mapped scan-position interrupt controller. It samples the pixel/line
// counters of the video timing path and detects two events:
//   - vblank start: the line counter enters VISIBLE_LINES
//   - compare line: the line counter enters the programmable LINE_CMP value
// Both events are latched as pending flags. Vblank starts are counted in a
// 16-bit frame counter. A single level interrupt goes to the CPU core.
//
// Register map (word offset from ADDRESS):
//   0 CTRL     RW    [0] vblank_en, [1] line_en
//   1 LINE_CMP RW    [15:0] compare line
//   2 STATUS   R/W1C [0] vblank_pend, [1] line_pend, [31:16] frame_cnt (RO)
//   3 POS      RO    {pixel_q, line_q}
//
// Ports:
//   cpu_clk       CPU clock; all state changes on its rising edge
//   reset         asynchronous, active-high reset
//   data_address  CPU word address (byte address >> 2)
//   data_bus      bidirectional CPU data bus; driven only during a read hit
//   data_cs       bus chip select
//   data_rw       1 = write, 0 = read
//   pixel         current pixel (x) position from the timing generator
//   line          current line (y) position from the timing generator
//   irq           level interrupt to the CPU
// -----------------------------------------------------------------------------
module gpu_line_irq_ctrl #(
    parameter logic [31:0] ADDRESS       = 32'h7000_0010,
    parameter int unsigned VISIBLE_LINES = 480,
    parameter logic [15:0] LINE_CMP_INIT = 16'd0
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [29:0] data_address,
    inout  wire  [31:0] data_bus,
    input  logic        data_cs,
    input  logic        data_rw,
    input  logic [15:0] pixel,
    input  logic [15:0] line,
    output logic        irq
);

    // The block occupies four words, so the upper 28 bits of the word
    // address select it and the lower two bits select the register.
    localparam logic [27:0] BASE_WORD   = ADDRESS[31:4];
    localparam logic [15:0] VBLANK_LINE = VISIBLE_LINES[15:0];

    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_LINE_CMP = 2'd1;
    localparam logic [1:0] OFF_STATUS   = 2'd2;
    localparam logic [1:0] OFF_POS      = 2'd3;

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    logic        w_hit;
    logic        w_rd;
    logic        w_wr;
    logic [1:0]  w_off;
    logic [31:0] w_wdata;
    logic        w_wr_ctrl;
    logic        w_wr_line_cmp;
    logic        w_wr_status;

    assign w_hit         = data_cs && (data_address[29:2] == BASE_WORD);
    assign w_off         = data_address[1:0];
    assign w_rd          = w_hit && !data_rw;
    assign w_wr          = w_hit && data_rw;
    assign w_wdata       = data_bus;
    assign w_wr_ctrl     = w_wr && (w_off == OFF_CTRL);
    assign w_wr_line_cmp = w_wr && (w_off == OFF_LINE_CMP);
    assign w_wr_status   = w_wr && (w_off == OFF_STATUS);
    // Writes to POS are decoded nowhere: the register is read-only.

    // Write data bits that no register stores.
    logic w_unused_wdata;
    assign w_unused_wdata = ^w_wdata[31:16];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic        r_vblank_en;
    logic        r_line_en;
    logic [15:0] r_line_cmp;
    logic        r_vblank_pend;
    logic        r_line_pend;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_pixel_q;
    logic [15:0] r_line_q;
    logic [15:0] r_line_prev;
    logic        r_q_valid;     // line_q holds a real sample
    logic        r_prev_valid;  // line_prev holds a real sample

    // -------------------------------------------------------------------------
    // Event detection
    // -------------------------------------------------------------------------
    // An event is the line counter entering a value, so a line that is held
    // constant fires only once. Both line_q and line_prev must be genuine
    // samples; otherwise the reset value of line_prev (0) would make any
    // non-zero line look like a fresh entry right after reset release.
    logic w_vb_evt;
    logic w_ln_evt;

    assign w_vb_evt = r_prev_valid
                      && (r_line_q == VBLANK_LINE)
                      && (r_line_prev != VBLANK_LINE);

    assign w_ln_evt = r_prev_valid
                      && (r_line_q == r_line_cmp)
                      && (r_line_prev != r_line_cmp);

    // -------------------------------------------------------------------------
    // Next-state logic for pending flags and frame counter
    // -------------------------------------------------------------------------
    logic        w_clr_vb;
    logic        w_clr_ln;
    logic        w_vblank_pend_next;
    logic        w_line_pend_next;
    logic [15:0] w_frame_cnt_next;

    assign w_clr_vb = w_wr_status && w_wdata[0];
    assign w_clr_ln = w_wr_status && w_wdata[1];

    // A set in the same cycle as a W1C clear wins, so an event is never lost
    // to a software acknowledge racing with it.
    always_comb begin
        w_vblank_pend_next = w_vb_evt | (r_vblank_pend & ~w_clr_vb);
        w_line_pend_next   = w_ln_evt | (r_line_pend & ~w_clr_ln);
        w_frame_cnt_next   = r_frame_cnt;
        if (w_vb_evt) begin
            w_frame_cnt_next = r_frame_cnt + 16'd1;  // wraps FFFF -> 0
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            r_pixel_q    <= 16'd0;
            r_line_q     <= 16'd0;
            r_line_prev  <= 16'd0;
            r_q_valid    <= 1'b0;
            r_prev_valid <= 1'b0;
        end else begin
            r_pixel_q    <= pixel;
            r_line_q     <= line;
            r_line_prev  <= r_line_q;
            r_q_valid    <= 1'b1;
            r_prev_valid <= r_q_valid;
        end
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            r_vblank_en <= 1'b0;
            r_line_en   <= 1'b0;
            r_line_cmp  <= LINE_CMP_INIT;
        end else begin
            if (w_wr_ctrl) begin
                r_vblank_en <= w_wdata[0];
                r_line_en   <= w_wdata[1];
            end
            // A new compare value is used by the event logic from the next
            // cycle on; if line_q already equals it, line_prev does too, so
            // the line must leave and re-enter before an event fires.
            if (w_wr_line_cmp) begin
                r_line_cmp <= w_wdata[15:0];
            end
        end
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            r_vblank_pend <= 1'b0;
            r_line_pend   <= 1'b0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_vblank_pend <= w_vblank_pend_next;
            r_line_pend   <= w_line_pend_next;
            r_frame_cnt   <= w_frame_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Interrupt: built only from registered terms, so it rises the cycle
    // after the event is seen and is glitch-free.
    // -------------------------------------------------------------------------
    assign irq = (r_vblank_pend & r_vblank_en) | (r_line_pend & r_line_en);

    // -------------------------------------------------------------------------
    // Read path: combinational, bus released whenever not a read hit
    // -------------------------------------------------------------------------
    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            OFF_CTRL:     w_rdata = {30'd0, r_line_en, r_vblank_en};
            OFF_LINE_CMP: w_rdata = {16'd0, r_line_cmp};
            OFF_STATUS:   w_rdata = {r_frame_cnt, 14'd0, r_line_pend, r_vblank_pend};
            OFF_POS:      w_rdata = {r_pixel_q, r_line_q};
            default:      w_rdata = 32'd0;
        endcase
    end

    assign data_bus = w_rd ? w_rdata : 32'bz;

endmodule
